// File: rtl/draw_scheduler.sv
// Frame sequencer for sprite draw channels: erase pass, position increment, draw pass.
// Merges the selected channel's pixel stream into a single registered frame-buffer write.
module draw_scheduler #(
    parameter int unsigned NCH = 3,
    parameter int unsigned XW  = 10,
    parameter int unsigned YW  = 10,
    parameter int unsigned CW  = 3,
    parameter int unsigned TW  = 20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              frame_tick,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [TW-1:0]     timeout,
    output logic [NCH-1:0]    ch_go,
    input  logic [NCH-1:0]    ch_done,
    input  logic [NCH-1:0]    ch_we,
    input  logic [NCH*XW-1:0] ch_x,
    input  logic [NCH*YW-1:0] ch_y,
    input  logic [NCH*CW-1:0] ch_colour,
    output logic [XW-1:0]     px_x,
    output logic [YW-1:0]     px_y,
    output logic [CW-1:0]     px_colour,
    output logic              px_we,
    output logic              inc_enable,
    output logic              busy,
    output logic              erase,
    output logic              overrun,
    output logic [NCH-1:0]    to_err
);

    localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        DRAW = 3'd2,
        NEXT = 3'd3,
        INC  = 3'd4
    } state_t;

    state_t          state;
    logic [NCH-1:0]  act_mask;
    logic            pending;
    logic [TW-1:0]   cnt;
    logic [SW-1:0]   sel;

    logic [SW:0]     first_new;
    logic [SW:0]     first_act;
    logic [SW:0]     next_act;
    logic            px_write;

    // Lowest set bit of m at or above start; MSB of the result is the found flag.
    function automatic logic [SW:0] find_from(input logic [NCH-1:0] m, input int start);
        logic [SW:0] r;
        r = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (i >= start && m[i]) r = {1'b1, SW'(i)};
        end
        return r;
    endfunction

    assign first_new = find_from(ch_mask, 0);
    assign first_act = find_from(act_mask, 0);
    assign next_act  = find_from(act_mask, int'(sel) + 1);
    assign px_write  = (state == DRAW) && ch_we[sel];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            act_mask   <= '0;
            pending    <= 1'b0;
            cnt        <= '0;
            sel        <= '0;
            ch_go      <= '0;
            px_x       <= '0;
            px_y       <= '0;
            px_colour  <= '0;
            px_we      <= 1'b0;
            inc_enable <= 1'b0;
            erase      <= 1'b0;
            overrun    <= 1'b0;
            to_err     <= '0;
        end else begin
            ch_go      <= '0;
            inc_enable <= 1'b0;
            px_we      <= px_write;
            if (px_write) begin
                px_x      <= ch_x[int'(sel)*XW +: XW];
                px_y      <= ch_y[int'(sel)*YW +: YW];
                px_colour <= erase ? '0 : ch_colour[int'(sel)*CW +: CW];
            end

            // A tick while busy queues one frame; a second queued tick is an overrun.
            if (frame_tick && state != IDLE) begin
                pending <= 1'b1;
                if (pending) overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_tick || pending) begin
                        act_mask <= ch_mask;
                        erase    <= 1'b1;
                        pending  <= 1'b0;
                        if (first_new[SW]) begin
                            sel   <= first_new[SW-1:0];
                            state <= LOAD;
                        end else begin
                            state <= INC;
                        end
                    end
                end
                LOAD: begin
                    ch_go <= NCH'(1) << sel;
                    cnt   <= '0;
                    state <= DRAW;
                end
                DRAW: begin
                    cnt <= cnt + TW'(1);
                    if (ch_done[sel]) begin
                        state <= NEXT;
                    end else if (timeout != '0 && cnt == timeout - TW'(1)) begin
                        to_err[sel] <= 1'b1;
                        state       <= NEXT;
                    end
                end
                NEXT: begin
                    if (next_act[SW]) begin
                        sel   <= next_act[SW-1:0];
                        state <= LOAD;
                    end else if (erase) begin
                        state <= INC;
                    end else begin
                        state <= IDLE;
                    end
                end
                INC: begin
                    inc_enable <= 1'b1;
                    erase      <= 1'b0;
                    if (first_act[SW]) begin
                        sel   <= first_act[SW-1:0];
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: per-frame vector table plus hand-written
// sequences for timeout length, overrun, pixel merge and mid-frame reset.
module tb_draw_scheduler;

    localparam int unsigned NCH = 3;
    localparam int unsigned XW  = 10;
    localparam int unsigned YW  = 10;
    localparam int unsigned CW  = 3;
    localparam int unsigned TW  = 20;
    localparam int DONE_DLY = 5;
    localparam int LIMIT    = 3000;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              frame_tick = 1'b0;
    logic [NCH-1:0]    ch_mask = '0;
    logic [TW-1:0]     timeout = '0;
    logic [NCH-1:0]    ch_go;
    logic [NCH-1:0]    ch_done = '0;
    logic [NCH-1:0]    ch_we = '0;
    logic [NCH*XW-1:0] ch_x = '0;
    logic [NCH*YW-1:0] ch_y = '0;
    logic [NCH*CW-1:0] ch_colour = '0;
    logic [XW-1:0]     px_x;
    logic [YW-1:0]     px_y;
    logic [CW-1:0]     px_colour;
    logic              px_we;
    logic              inc_enable;
    logic              busy;
    logic              erase;
    logic              overrun;
    logic [NCH-1:0]    to_err;

    draw_scheduler #(.NCH(NCH), .XW(XW), .YW(YW), .CW(CW), .TW(TW)) dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .ch_mask(ch_mask),
        .timeout(timeout), .ch_go(ch_go), .ch_done(ch_done), .ch_we(ch_we),
        .ch_x(ch_x), .ch_y(ch_y), .ch_colour(ch_colour), .px_x(px_x), .px_y(px_y),
        .px_colour(px_colour), .px_we(px_we), .inc_enable(inc_enable), .busy(busy),
        .erase(erase), .overrun(overrun), .to_err(to_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [NCH-1:0] hang = '0;
    int          rem [NCH];
    logic [31:0] seq = '0;
    int          go_cnt = 0;
    int          inc_cnt = 0;
    logic        log_en = 1'b0;

    // Channel model (done DONE_DLY cycles after go unless hung) and event log.
    // Log nibbles: {erase, channel} for each go, F for inc_enable.
    always @(negedge clk) begin
        for (int i = 0; i < int'(NCH); i++) begin
            if (!resetn) rem[i] = 0;
            else if (ch_go[i]) rem[i] = DONE_DLY;
            else if (rem[i] > 0) rem[i] = rem[i] - 1;
            ch_done[i] = (rem[i] == 1) && !hang[i];
        end
        if (log_en) begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (ch_go[i]) begin
                    seq = {seq[27:0], erase, 3'(i)};
                    go_cnt = go_cnt + 1;
                end
            end
            if (inc_enable) begin
                seq = {seq[27:0], 4'hF};
                inc_cnt = inc_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s: wait expired after %0d cycles, required event never seen", name, LIMIT);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        seq = '0;
        go_cnt = 0;
        inc_cnt = 0;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Wait until busy has been low for three consecutive cycles.
    task automatic wait_quiet(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < LIMIT) begin
            @(negedge clk);
            n = n + 1;
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 3) bound_fail(name);
    endtask

    task automatic wait_go(input string name, input int ch, input logic want_erase);
        int n = 0;
        while (!(ch_go[ch] && erase == want_erase) && n < LIMIT) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= LIMIT) bound_fail(name);
    endtask

    task automatic wait_inc(input string name);
        int n = 0;
        while (!inc_enable && n < LIMIT) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= LIMIT) bound_fail(name);
    endtask

    typedef struct {
        logic [NCH-1:0] mask;
        logic [TW-1:0]  tmo;
        logic [NCH-1:0] hang;
        logic [31:0]    seq;
        int             go_n;
        logic [NCH-1:0] err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{mask: 3'b111, tmo: 20'd0, hang: 3'b000, seq: 32'h089AF012, go_n: 6, err: 3'b000};
        vecs[1] = '{mask: 3'b101, tmo: 20'd0, hang: 3'b000, seq: 32'h0008AF02, go_n: 4, err: 3'b000};
        vecs[2] = '{mask: 3'b111, tmo: 20'd8, hang: 3'b010, seq: 32'h089AF012, go_n: 6, err: 3'b010};
        vecs[3] = '{mask: 3'b001, tmo: 20'd5, hang: 3'b000, seq: 32'h000008F0, go_n: 2, err: 3'b000};
        vecs[4] = '{mask: 3'b111, tmo: 20'd4, hang: 3'b000, seq: 32'h089AF012, go_n: 6, err: 3'b111};
        vecs[5] = '{mask: 3'b000, tmo: 20'd0, hang: 3'b000, seq: 32'h0000000F, go_n: 0, err: 3'b000};
        vecs[6] = '{mask: 3'b010, tmo: 20'd0, hang: 3'b000, seq: 32'h000009F1, go_n: 2, err: 3'b000};
        vecs[7] = '{mask: 3'b100, tmo: 20'd0, hang: 3'b000, seq: 32'h00000AF2, go_n: 2, err: 3'b000};

        // Outputs while reset is held
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_go", 32'(ch_go), 32'd0);
        check("rst_px", {px_we, 1'b0, px_colour, px_y, px_x} == '0 ? 32'd0 : 32'd1, 32'd0);
        check("rst_inc", 32'(inc_enable), 32'd0);
        check("rst_flags", {29'd0, erase, overrun, |to_err}, 32'd0);
        resetn = 1'b1;
        log_en = 1'b1;

        // Whole-frame vectors
        for (int k = 0; k < 8; k++) begin
            do_reset();
            ch_mask = vecs[k].mask;
            timeout = vecs[k].tmo;
            hang    = vecs[k].hang;
            pulse_tick();
            wait_quiet($sformatf("v%0d_quiet", k));
            check($sformatf("v%0d_seq", k), seq, vecs[k].seq);
            check($sformatf("v%0d_go_n", k), 32'(go_cnt), 32'(vecs[k].go_n));
            check($sformatf("v%0d_inc_n", k), 32'(inc_cnt), 32'd1);
            check($sformatf("v%0d_to_err", k), 32'(to_err), 32'(vecs[k].err));
            check($sformatf("v%0d_overrun", k), 32'(overrun), 32'd0);
        end

        // Hung channel leaves DRAW after exactly timeout cycles
        do_reset();
        ch_mask = 3'b010;
        timeout = 20'd8;
        hang    = 3'b010;
        pulse_tick();
        wait_go("to_go", 1, 1'b1);
        begin
            int n = 0;
            while (!to_err[1] && n < 100) begin
                @(negedge clk);
                n = n + 1;
            end
            check("to_cycles", 32'(n), 32'd8);
        end
        wait_quiet("to_quiet");
        hang = '0;

        // Two ticks while busy: overrun, one extra frame using the new mask
        do_reset();
        ch_mask = 3'b001;
        timeout = '0;
        pulse_tick();
        ch_mask = 3'b010;
        check("ovr_busy", 32'(busy), 32'd1);
        pulse_tick();
        check("ovr_one_pending", 32'(overrun), 32'd0);
        pulse_tick();
        check("ovr_set", 32'(overrun), 32'd1);
        wait_quiet("ovr_quiet");
        check("ovr_seq", seq, 32'h008F09F1);
        check("ovr_inc_n", 32'(inc_cnt), 32'd2);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Pixel merge: erase pass forces colour 0, draw pass passes it through
        do_reset();
        ch_mask   = 3'b001;
        ch_we     = 3'b011;
        ch_x      = {10'd0, 10'd99, 10'd12};
        ch_y      = {10'd0, 10'd55, 10'd7};
        ch_colour = {3'd0, 3'd3, 3'd5};
        check("px_idle_x", 32'(px_x), 32'd0);
        pulse_tick();
        wait_go("px_go_erase", 0, 1'b1);
        @(negedge clk);
        check("px_erase", {px_we, 3'b0, 4'(px_colour), 12'(px_y), 12'(px_x)}, {1'b1, 3'b0, 4'd0, 12'd7, 12'd12});
        wait_go("px_go_draw", 0, 1'b0);
        @(negedge clk);
        check("px_draw", {px_we, 3'b0, 4'(px_colour), 12'(px_y), 12'(px_x)}, {1'b1, 3'b0, 4'd5, 12'd7, 12'd12});
        wait_quiet("px_quiet");
        check("px_hold", {px_we, 3'b0, 4'(px_colour), 12'(px_y), 12'(px_x)}, {1'b0, 3'b0, 4'd5, 12'd7, 12'd12});

        // Reset in DRAW of the draw pass, then an empty-mask frame
        do_reset();
        ch_mask = 3'b111;
        timeout = 20'd4;
        ch_we   = 3'b001;
        pulse_tick();
        wait_inc("mid_inc");
        wait_go("mid_go", 0, 1'b0);
        check("mid_pre_err", 32'(to_err), 32'h7);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_outs", {8'(ch_go), 7'd0, px_we, inc_enable, 3'(px_colour), 12'(px_x)}, 32'd0);
        check("mid_flags", {28'd0, 1'b0, erase, overrun, |to_err}, 32'd0);
        resetn = 1'b1;
        ch_we = '0;
        ch_mask = 3'b000;
        seq = '0;
        go_cnt = 0;
        inc_cnt = 0;
        @(negedge clk);
        pulse_tick();
        wait_quiet("mid_quiet");
        check("mid_empty_seq", seq, 32'h0000000F);
        check("mid_empty_go", 32'(go_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter NCH, default 3: number of sprite draw channels (1..8).
REQ-002 Parameter XW, default 10: x coordinate width.
REQ-003 Parameter YW, default 10: y coordinate width.
REQ-004 Parameter CW, default 3: colour width.
REQ-005 Parameter TW, default 20: timeout counter width.
REQ-006 Port clk  in  1  rising-edge clock.
REQ-007 Port resetn  in  1  reset, synchronous, active-low.
REQ-008 Port frame_tick  in  1  one-cycle frame start request.
REQ-009 Port ch_mask  in  NCH  per-channel enable, sampled at frame start.
REQ-010 Port timeout  in  TW  max DRAW cycles per channel; 0 = no timeout.
REQ-011 Port ch_go  out  NCH  one-cycle start pulse to channel i.
REQ-012 Port ch_done  in  NCH  channel i finished its pixel stream.
REQ-013 Port ch_we, ch_x, ch_y, ch_colour  in  NCH, NCH*XW, NCH*YW, NCH*CW  per-channel pixel stream; channel i occupies slice [i*W +: W].
REQ-014 Port px_x, px_y, px_colour, px_we  out  XW, YW, CW, 1  merged pixel write to the frame buffer.
REQ-015 Port inc_enable  out  1  one-cycle pulse: advance game positions.
REQ-016 Port busy  out  1  high whenever state != IDLE.
REQ-017 Port erase  out  1  high during the erase pass.
REQ-018 Port overrun  out  1  sticky; frame_tick arrived while a request was already pending.
REQ-019 Port to_err  out  NCH  sticky per-channel timeout flags.

Function
REQ-020 States: IDLE, LOAD, DRAW, NEXT, INC; the phase bit selects erase pass (1) or draw pass (0).
REQ-021 IDLE: on frame_tick or pending flag -> latch mask into act_mask, set erase=1, clear pending, select lowest set bit of act_mask -> LOAD; if act_mask==0 -> INC.
REQ-022 LOAD: assert ch_go[sel] for exactly one cycle, clear the cycle counter -> DRAW.
REQ-023 DRAW: counter increments each cycle; ch_done[sel] -> NEXT; else timeout!=0 and counter==timeout-1 -> set to_err[sel] -> NEXT.
REQ-024 ch_done[sel] and timeout in the same cycle: treated as done; to_err is not set.
REQ-025 NEXT: select the next higher set bit of act_mask -> LOAD; if none left, erase pass -> INC, draw pass -> IDLE.
REQ-026 INC: pulse inc_enable for one cycle, set erase=0, select the lowest set bit -> LOAD; if act_mask==0 -> IDLE.
REQ-027 Per frame, the erase pass precedes inc_enable, which precedes the draw pass; inc_enable pulses exactly once per frame.
REQ-028 ch_done from non-selected channels, and ch_done outside DRAW, is ignored.
REQ-029 Pixel outputs are registered with 1-cycle latency: px_we <= (state==DRAW) & ch_we[sel]; px_x, px_y take the sel channel values.
REQ-030 px_colour <= erase ? 0 : ch_colour[sel].
REQ-031 px_x, px_y, px_colour hold their values when px_we=0.
REQ-032 frame_tick while busy: set pending. If pending is already set, also set overrun. The request is serviced on the IDLE entry.
REQ-033 frame_tick in IDLE: accepted immediately; pending is not set.
REQ-034 act_mask is constant for the whole frame; ch_mask changes mid-frame take effect at the next frame.

Reset
REQ-035 resetn=0 at a clk edge, including mid-frame, forces state IDLE, erase=0, and clears pending, act_mask, counter, sel, overrun and to_err.
REQ-036 While in reset, outputs are 0: ch_go, px_we, px_x, px_y, px_colour, inc_enable, busy.
REQ-037 The first frame_tick after reset release is accepted normally.

Verification
REQ-038 NCH=3, mask=111, each channel asserts done 5 cycles after go, frame_tick -> erase-pass ch_go order 0,1,2 -> one inc_enable -> draw-pass order 0,1,2 -> IDLE; px_colour=0 in the erase pass.
REQ-039 mask=101 -> ch_go[1] is never asserted; the frame contains exactly four ch_go pulses.
REQ-040 timeout=8, channel 1 never asserts done -> channel 1 leaves DRAW after 8 cycles, to_err=010, frame completes.
REQ-041 Two frame_ticks during a busy frame -> overrun=1; exactly one additional frame runs afterwards.
REQ-042 ch_we[0]=1 with x=12, y=7, colour=5 in the draw pass -> next cycle px_we=1, px_x=12, px_y=7, px_colour=5.
REQ-043 resetn=0 in the DRAW state of the draw pass -> next cycle busy=0, outputs 0, to_err=0; mask=000 with frame_tick -> inc_enable pulses, no ch_go is asserted, back to IDLE.
